// File: rtl/d_input_debouncer.sv
// d_input_debouncer: synchronizes a raw, possibly bouncing level and accepts a
// new level only after STABLE_CYCLES consecutive enabled samples of it.
// Produces the clean level plus one-cycle rise/fall strobes and a busy flag.
module d_input_debouncer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din_raw,
    input  logic sample_en,
    output logic d_clean,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    // Count value on which the last qualifying sample is taken.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    // With a single required sample, a change is accepted on its first sample.
    localparam bit               ONE_SAMPLE = (STABLE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             d_clean_q, d_clean_d;
    logic             rise_q,    rise_d;
    logic             fall_q,    fall_d;
    logic             busy_q,    busy_d;

    // Synchronizer chain: shifts every clock, independent of sample_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_LOW;
            cnt_q     <= '0;
            d_clean_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_clean_q <= d_clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic; everything holds and strobes drop on disabled edges.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_clean_d = d_clean_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;

        if (sample_en) begin
            unique case (state_q)
                S_LOW: begin
                    if (s) begin
                        if (ONE_SAMPLE) begin
                            state_d   = S_HIGH;
                            d_clean_d = 1'b1;
                            rise_d    = 1'b1;
                        end else begin
                            state_d = S_WAIT_HI;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                S_WAIT_HI: begin
                    if (!s) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = S_HIGH;
                        d_clean_d = 1'b1;
                        rise_d    = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!s) begin
                        if (ONE_SAMPLE) begin
                            state_d   = S_LOW;
                            d_clean_d = 1'b0;
                            fall_d    = 1'b1;
                        end else begin
                            state_d = S_WAIT_LO;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                S_WAIT_LO: begin
                    if (s) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = S_LOW;
                        d_clean_d = 1'b0;
                        fall_d    = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d == S_WAIT_HI) || (state_d == S_WAIT_LO);
    end

    assign d_clean    = d_clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

endmodule
